// File: rtl/wiring_sequencer_pkg.sv
// Shared controller definitions for the wiring sequencer family: state
// encodings, default widths and the saturating-increment helper.
// No ports (package).
package wiring_sequencer_pkg;

  localparam int unsigned DEF_INPUT_WIDTH  = 2;
  localparam int unsigned DEF_OUTPUT_WIDTH = 1;
  localparam int unsigned DEF_PULSE_CYCLES = 1;
  localparam int unsigned DEF_MAX_CYCLES   = 1024;
  localparam int unsigned DEF_CNT_WIDTH    = 16;

  // Sequencer states, 3-bit encoded
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRIVE   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_CLEAR   = 3'd3,
    ST_RESPOND = 3'd4
  } state_t;

  // All-ones value of a w-bit counter, expressed in 32 bits
  function automatic logic [31:0] cnt_max(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  // Increment that sticks at max_v instead of wrapping
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/wiring_settle_timer.sv
// Saturating evaluation-cycle counter with a registered timeout flag.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   clear        zero the count (wins over enable)
//   enable       count this cycle
//   count        cycles counted so far (saturating at 2^CNT_WIDTH-1)
//   expired      the cycle now in progress is cycle MAX_CYCLES or later
module wiring_settle_timer
  import wiring_sequencer_pkg::*;
#(
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int unsigned MAX_CYCLES = DEF_MAX_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 enable,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 expired
);

  localparam logic [31:0] CNT_MAX = cnt_max(CNT_WIDTH);
  // count holds completed cycles, so the MAX_CYCLES-th cycle is running
  // once count reaches MAX_CYCLES-1
  localparam logic [31:0] EXP_AT  = 32'(MAX_CYCLES - 1);

  logic [CNT_WIDTH-1:0] count_d;

  // Next count
  always_comb begin
    count_d = count;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = CNT_WIDTH'(sat_inc(32'(count), CNT_MAX));
    end
  end

  // Count and expiry flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      expired <= 1'b0;
    end else begin
      count   <= count_d;
      expired <= (32'(count_d) >= EXP_AT);
    end
  end

endmodule

// File: rtl/wiring_sequencer.sv
// Drives one Wiring instance one request at a time: pulse the trigger
// vector, wait for activity to settle (or time out), capture the output,
// clear gate state with a one-cycle logic_reset, then hand back a response.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   req_valid/req_ready/req_in    request stream (req_ready is combinational)
//   wiring_in, logic_reset        registered drives to the Wiring block
//   wiring_running, wiring_out    status/result from the Wiring block
//   rsp_valid/rsp_ready           response handshake
//   rsp_out, rsp_cycles,
//   rsp_timeout                   captured result, DRIVE+SETTLE cycles, timeout
//   busy                          registered, high whenever not IDLE
module wiring_sequencer
  import wiring_sequencer_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH  = DEF_INPUT_WIDTH,
  parameter int unsigned OUTPUT_WIDTH = DEF_OUTPUT_WIDTH,
  parameter int unsigned PULSE_CYCLES = DEF_PULSE_CYCLES,
  parameter int unsigned MAX_CYCLES   = DEF_MAX_CYCLES,
  parameter int unsigned CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [INPUT_WIDTH-1:0]  req_in,
  output logic [INPUT_WIDTH-1:0]  wiring_in,
  input  logic                    wiring_running,
  input  logic [OUTPUT_WIDTH-1:0] wiring_out,
  output logic                    logic_reset,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [OUTPUT_WIDTH-1:0] rsp_out,
  output logic [CNT_WIDTH-1:0]    rsp_cycles,
  output logic                    rsp_timeout,
  output logic                    busy
);

  localparam logic [31:0] CNT_MAX    = cnt_max(CNT_WIDTH);
  localparam logic [31:0] DRIVE_LAST = 32'(PULSE_CYCLES - 1);

  state_t                  state_q, state_d;
  logic [INPUT_WIDTH-1:0]  vec_q, vec_d;
  logic [INPUT_WIDTH-1:0]  wiring_in_d;
  logic                    logic_reset_d;
  logic                    rsp_valid_d;
  logic [OUTPUT_WIDTH-1:0] rsp_out_d;
  logic [CNT_WIDTH-1:0]    rsp_cycles_d;
  logic                    rsp_timeout_d;
  logic                    busy_d;
  logic                    timer_clear;
  logic                    timer_enable;
  logic [CNT_WIDTH-1:0]    count;
  logic                    expired;

  assign req_ready = (state_q == ST_IDLE);

  // Evaluation cycle counter; also paces the DRIVE pulse
  wiring_settle_timer #(
    .CNT_WIDTH  (CNT_WIDTH),
    .MAX_CYCLES (MAX_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .count   (count),
    .expired (expired)
  );

  // Next state and next values of the registered outputs
  always_comb begin
    state_d       = state_q;
    vec_d         = vec_q;
    wiring_in_d   = '0;
    logic_reset_d = 1'b0;
    rsp_valid_d   = rsp_valid;
    rsp_out_d     = rsp_out;
    rsp_cycles_d  = rsp_cycles;
    rsp_timeout_d = rsp_timeout;
    timer_clear   = 1'b0;
    timer_enable  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          vec_d       = req_in;
          wiring_in_d = req_in;
          timer_clear = 1'b1;
          state_d     = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        timer_enable = 1'b1;
        // count equals DRIVE cycles already completed
        if (32'(count) >= DRIVE_LAST) begin
          state_d = ST_SETTLE;
        end else begin
          wiring_in_d = vec_q;
        end
      end
      ST_SETTLE: begin
        timer_enable = 1'b1;
        // Settling takes precedence over a simultaneous timeout
        if (!wiring_running || expired) begin
          rsp_out_d     = wiring_out;
          rsp_timeout_d = wiring_running;
          rsp_cycles_d  = CNT_WIDTH'(sat_inc(32'(count), CNT_MAX));
          logic_reset_d = 1'b1;
          state_d       = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        rsp_valid_d = 1'b1;
        state_d     = ST_RESPOND;
      end
      ST_RESPOND: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; logic_reset follows reset so the wiring clears too
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      vec_q       <= '0;
      wiring_in   <= '0;
      logic_reset <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_out     <= '0;
      rsp_cycles  <= '0;
      rsp_timeout <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      wiring_in   <= wiring_in_d;
      logic_reset <= logic_reset_d;
      rsp_valid   <= rsp_valid_d;
      rsp_out     <= rsp_out_d;
      rsp_cycles  <= rsp_cycles_d;
      rsp_timeout <= rsp_timeout_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_wiring_sequencer.sv
// Scoreboard bench for wiring_sequencer with a behavioural AND-gate wiring.
module tb_wiring_sequencer;

  localparam int IW   = 2;
  localparam int OW   = 1;
  localparam int P    = 1;
  localparam int MAXC = 8;
  localparam int CW   = 16;

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [IW-1:0] req_in;
  logic [IW-1:0] wiring_in;
  logic          wiring_running;
  logic [OW-1:0] wiring_out;
  logic          logic_reset;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [OW-1:0] rsp_out;
  logic [CW-1:0] rsp_cycles;
  logic          rsp_timeout;
  logic          busy;

  wiring_sequencer #(
    .INPUT_WIDTH  (IW),
    .OUTPUT_WIDTH (OW),
    .PULSE_CYCLES (P),
    .MAX_CYCLES   (MAXC),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_in         (req_in),
    .wiring_in      (wiring_in),
    .wiring_running (wiring_running),
    .wiring_out     (wiring_out),
    .logic_reset    (logic_reset),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_out        (rsp_out),
    .rsp_cycles     (rsp_cycles),
    .rsp_timeout    (rsp_timeout),
    .busy           (busy)
  );

  // One expected transaction: request, wiring behaviour, predicted result
  typedef struct {
    logic [IW-1:0] vec;
    int            d;      // SETTLE cycles the wiring stays running
    logic [OW-1:0] out;
    int            cycles;
    logic          to;
    int            acc;    // posedge number at which the request is accepted
  } exp_t;

  exp_t q[$];
  int   errors  = 0;
  int   checks  = 0;
  int   cyc     = 0;
  int   last_hs = -1;
  int   n_done  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the wiring is an AND gate that stays running for d
  // SETTLE cycles after a nonzero pulse, showing the inverted value while
  // running. The evaluation lasts P drive cycles plus SETTLE cycles up to
  // the first quiet one, capped at MAXC (a tie at MAXC counts as settled).
  function automatic exp_t model(input logic [IW-1:0] vec, input int d);
    exp_t e;
    int   eff;
    e.vec = vec;
    e.d   = d;
    e.acc = 0;
    eff   = (vec == '0) ? 0 : d;
    if (P + eff + 1 <= MAXC) begin
      e.cycles = P + eff + 1;
      e.to     = 1'b0;
      e.out    = &vec;
    end else begin
      e.cycles = MAXC;
      e.to     = 1'b1;
      e.out    = ~(&vec);
    end
    return e;
  endfunction

  // Wiring model, response-ready policy and response monitor
  initial begin
    int            left;
    int            drv_cnt;
    int            drv_bad;
    int            lr_cnt;
    int            stall_left;
    bit            stall_set;
    bit            seen;
    bit            expect_low;
    logic [IW-1:0] cv;
    exp_t          e;
    wiring_running = 1'b0;
    wiring_out     = '0;
    rsp_ready      = 1'b0;
    left = 0; drv_cnt = 0; drv_bad = 0; lr_cnt = 0;
    stall_left = 0; stall_set = 0; seen = 0; expect_low = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        wiring_running = 1'b0;
        wiring_out     = '0;
        rsp_ready      = 1'b0;
        left = 0; seen = 0; expect_low = 0; stall_set = 0; stall_left = 0;
      end else begin
        if (q.size() == 0) begin
          drv_cnt = 0; drv_bad = 0; lr_cnt = 0;
        end
        cv = (q.size() > 0) ? q[0].vec : '0;
        if (wiring_in != '0) begin
          drv_cnt++;
          if (wiring_in != cv) drv_bad++;
        end
        if (logic_reset) lr_cnt++;

        if (logic_reset) begin
          wiring_running = 1'b0;
          left = 0;
        end else if (wiring_in != '0) begin
          wiring_running = 1'b1;
          left = (q.size() > 0) ? q[0].d : 0;
        end else if (left > 0) begin
          wiring_running = 1'b1;
          left--;
        end else begin
          wiring_running = 1'b0;
        end
        wiring_out = wiring_running ? ~(&cv) : (&cv);

        if (expect_low) begin
          chk("rsp_valid_drop", rsp_valid, 0);
          expect_low = 0;
        end

        if (!rsp_valid) begin
          stall_set = 0;
          rsp_ready = 1'($urandom_range(0, 1));
        end else begin
          if (!stall_set) begin
            stall_set  = 1;
            stall_left = (n_done % 5 == 3) ? 10 : int'($urandom_range(0, 3));
          end
          if (stall_left > 0) begin
            rsp_ready = 1'b0;
            stall_left--;
          end else begin
            rsp_ready = 1'b1;
          end
        end

        if (rsp_valid) begin
          if (q.size() == 0) begin
            chk("rsp_valid_unexpected", rsp_valid, 0);
          end else begin
            e = q[0];
            if (!seen) begin
              chk("latency", cyc, e.acc + e.cycles + 1);
              seen = 1;
            end
            chk("rsp_out", rsp_out, e.out);
            chk("rsp_cycles", rsp_cycles, e.cycles);
            chk("rsp_timeout", rsp_timeout, e.to);
            chk("req_ready_in_respond", req_ready, 0);
            chk("busy_in_respond", busy, 1);
            if (rsp_ready) begin
              chk("drive_cycles", drv_cnt, (e.vec != '0) ? P : 0);
              chk("drive_value_bad", drv_bad, 0);
              chk("logic_reset_pulses", lr_cnt, 1);
              void'(q.pop_front());
              last_hs    = cyc + 1;
              seen       = 0;
              expect_low = 1;
              drv_cnt = 0; drv_bad = 0; lr_cnt = 0;
              n_done++;
            end
          end
        end
      end
    end
  end

  // Present one request; returns on the negedge after it is accepted
  task automatic send(input logic [IW-1:0] vec, input int d, input bit gap, input bit b2b_check);
    int   n;
    exp_t e;
    if (gap) repeat ($urandom_range(1, 3)) @(negedge clk);
    req_in    = vec;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", req_ready, 1);
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    e     = model(vec, d);
    e.acc = cyc + 1;
    if (b2b_check && !gap && last_hs >= 0) chk("back_to_back_accept", e.acc, last_hs + 1);
    q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    req_in    = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
  endtask

  initial begin
    int n;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_in    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_wiring_in", wiring_in, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_out", rsp_out, 0);
    chk("reset_rsp_cycles", rsp_cycles, 0);
    chk("reset_rsp_timeout", rsp_timeout, 0);
    chk("reset_busy", busy, 0);
    chk("reset_logic_reset", logic_reset, 1);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", req_ready, 1);
    chk("idle_logic_reset", logic_reset, 0);

    // Directed: AND 11 settles, AND 01, zero vector, hung wiring,
    // settle exactly at the limit, one cycle past the limit
    send(2'b11, 1, 1'b1, 1'b0);
    send(2'b01, 1, 1'b0, 1'b1);
    send(2'b00, 5, 1'b0, 1'b1);
    send(2'b11, 1000, 1'b0, 1'b1);
    send(2'b10, 1000, 1'b1, 1'b0);
    send(2'b11, MAXC - P - 1, 1'b0, 1'b1);
    send(2'b11, MAXC - P, 1'b0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      send(IW'($urandom_range(0, 3)), int'($urandom_range(0, 9)), 1'($urandom_range(0, 1)), 1'b1);
    end
    drain();

    // Reset while SETTLE is waiting on hung wiring: request is abandoned
    send(2'b11, 1000, 1'b1, 1'b0);
    @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_busy", busy, 0);
    chk("midreset_wiring_in", wiring_in, 0);
    chk("midreset_rsp_valid", rsp_valid, 0);
    chk("midreset_logic_reset", logic_reset, 1);
    @(negedge clk);
    chk("midreset_logic_reset_held", logic_reset, 1);
    q.delete();
    reset = 1'b0;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid) n++;
    end
    chk("aborted_no_response", n, 0);
    chk("post_reset_req_ready", req_ready, 1);

    send(2'b11, 2, 1'b1, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wiring_sequencer.md
Name: wiring_sequencer

Overview:
- Controller that drives one Wiring instance one request at a time: accepts an input trigger vector, pulses it onto the wiring inputs, waits for wire activity to settle, captures the output, then clears gate state with a logic_reset pulse.
- Sits between a host/testbench request stream and the Wiring block's in/out/logic_reset/wiring_running ports.
- Adds a settle timeout and a cycle count per evaluation.

Parameters:
- INPUT_WIDTH, 2, width of trigger vector and wiring_in.
- OUTPUT_WIDTH, 1, width of wiring_out and rsp_out.
- PULSE_CYCLES, 1, cycles the trigger vector is held on wiring_in (>=1).
- MAX_CYCLES, 1024, settle timeout measured from the first DRIVE cycle (>= PULSE_CYCLES+1).
- CNT_WIDTH, 16, width of rsp_cycles.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_in  in  INPUT_WIDTH  trigger vector.
- wiring_in  out  INPUT_WIDTH  to Wiring.in.
- wiring_running  in  1  from Wiring.wiring_running.
- wiring_out  in  OUTPUT_WIDTH  from Wiring.out.
- logic_reset  out  1  to Wiring.logic_reset.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_out  out  OUTPUT_WIDTH  captured wiring_out.
- rsp_cycles  out  CNT_WIDTH  cycles spent in DRIVE+SETTLE, saturating.
- rsp_timeout  out  1  settle did not complete within MAX_CYCLES.
- busy  out  1  state != IDLE.

Behaviour:
- States: IDLE, DRIVE, SETTLE, CLEAR, RESPOND. All are registered.
- Reset, sampled on a clk edge:
  - state=IDLE; counters=0.
  - wiring_in=0; rsp_valid=0; rsp_out=0; rsp_cycles=0; rsp_timeout=0.
  - req_ready=1 after reset deasserts.
  - logic_reset is 1 while reset is high, so the wiring clears alongside the sequencer.
  - Reset mid-operation abandons the request with no response.
- IDLE:
  - req_ready=1 combinationally, in IDLE only.
  - When req_valid & req_ready, latch req_in, clear the cycle counter and go to DRIVE.
  - A request with req_in=0 is still processed.
- DRIVE:
  - wiring_in = latched vector (registered output) for exactly PULSE_CYCLES cycles, then SETTLE.
  - wiring_in is 0 in every other state.
- SETTLE:
  - wiring_in=0.
  - Each cycle, if wiring_running==0: capture wiring_out into rsp_out, set rsp_timeout=0, go to CLEAR.
  - Else, if the counter has reached MAX_CYCLES: capture wiring_out, set rsp_timeout=1, go to CLEAR.
  - If both conditions hold in the same cycle, settle wins (timeout=0).
- Cycle counter:
  - Increments each cycle in DRIVE and SETTLE.
  - Saturates at 2^CNT_WIDTH-1.
  - Copied to rsp_cycles on leaving SETTLE.
- CLEAR: logic_reset=1 for exactly one cycle, then RESPOND.
- RESPOND:
  - rsp_valid=1, with rsp_out/rsp_cycles/rsp_timeout held stable until rsp_valid & rsp_ready.
  - On that handshake, rsp_valid drops next cycle and state returns to IDLE.
  - rsp_ready asserted before RESPOND has no effect.
- Minimum latency, from acceptance edge to rsp_valid high:
  - PULSE_CYCLES+3 cycles: PULSE_CYCLES DRIVE cycles + 1 SETTLE + 1 CLEAR, with rsp_valid visible on the following cycle.
  - Back-to-back requests: the next request is accepted the cycle after the response handshake.
- Outputs other than req_ready are registered. There are no combinational paths from req_valid or rsp_ready to outputs.

Decomposition:
- Shared header wiring_ctrl_defs holds:
  - state encodings (3-bit localparams);
  - default widths;
  - the saturating-increment helper.
- One natural sub-module: wiring_settle_timer.
  - Inputs: clear, enable, MAX_CYCLES compare.
  - Outputs: count, expired.
  - Reused by future multi-instance schedulers.

Test Plan:
- AND wiring (INPUT_WIDTH=2), req_in=2'b11, running drops 2 cycles after pulse, rsp_ready=1:
  - wiring_in=11 for 1 cycle, then 0.
  - logic_reset is a single pulse.
  - rsp_out=1, rsp_timeout=0, rsp_cycles=3.
- Same wiring, req_in=2'b01 -> rsp_out=0, rsp_timeout=0; next request accepted the cycle after the handshake.
- req_in=0 with running already low:
  - rsp_valid at acceptance+4 (PULSE_CYCLES=1);
  - rsp_cycles=2, rsp_out=0.
- wiring_running held high forever, MAX_CYCLES=8:
  - rsp_timeout=1, rsp_cycles=8;
  - logic_reset pulses once; returns to IDLE after handshake.
- rsp_ready held low 10 cycles in RESPOND:
  - rsp_valid and data stable throughout; req_ready=0; req_valid ignored.
- reset asserted during SETTLE:
  - next cycle: state IDLE, wiring_in=0, rsp_valid=0;
  - logic_reset=1 while reset is high;
  - no response is produced for the aborted request.
